// File: rtl/display_scan.sv
// Four-digit seven-segment scan driver: frame-aligned value update with load/updated handshake.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic [1:0]  digit,
  output logic [3:0]  num,
  output logic        blank,
  output logic        updated
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("display_scan: CLK_HZ/SCAN_HZ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;
  logic [15:0]   r_shadow;
  logic [15:0]   r_pend_val;
  logic          r_pending;
  logic          r_updated;

  logic w_tick;
  logic w_frame;

  assign w_tick  = (r_cnt == CNT_LAST);
  assign w_frame = w_tick && (r_digit == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_digit    <= 2'd0;
      r_shadow   <= 16'h0000;
      r_pend_val <= 16'h0000;
      r_pending  <= 1'b0;
      r_updated  <= 1'b0;
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + 1'b1;
      r_updated <= 1'b0;
      if (w_tick) begin
        r_digit <= r_digit + 2'd1;
      end
      // A load landing on the boundary bypasses the pending register entirely.
      if (w_frame) begin
        if (load) begin
          r_shadow  <= value_in;
          r_pending <= 1'b0;
          r_updated <= 1'b1;
        end else if (r_pending) begin
          r_shadow  <= r_pend_val;
          r_pending <= 1'b0;
          r_updated <= 1'b1;
        end
      end else if (load) begin
        r_pend_val <= value_in;
        r_pending  <= 1'b1;
      end
    end
  end

  assign digit   = r_digit;
  assign num     = r_shadow[{r_digit, 2'b00} +: 4];
  assign updated = r_updated;

`ifdef LEADING_ZERO_BLANK_EN
  logic w_blank;
  always_comb begin
    w_blank = 1'b0;
    case (r_digit)
      2'd1:    w_blank = (r_shadow[15:4]  == 12'h000);
      2'd2:    w_blank = (r_shadow[15:8]  == 8'h00);
      2'd3:    w_blank = (r_shadow[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
  end
  assign blank = w_blank;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIV = 4 (CLK_HZ = 8, SCAN_HZ = 2).
module tb_display_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [1:0]  digit;
  logic [3:0]  num;
  logic        blank;
  logic        updated;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value_in (value_in),
    .load     (load),
    .digit    (digit),
    .num      (num),
    .blank    (blank),
    .updated  (updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic exp_blank(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d != 0) && ((v >> (4 * d)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  // Checks all four outputs against the value expected to be on display.
  task automatic chk_out(input string tag, input int d, input int u, input logic [15:0] shown);
    chk({tag, ".digit"},   32'(digit),   32'(d));
    chk({tag, ".num"},     32'(num),     32'(nib(shown, d)));
    chk({tag, ".updated"}, 32'(updated), 32'(u));
    chk({tag, ".blank"},   32'(blank),   32'(exp_blank(shown, d)));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and free-running scan
    cyc(2);
    chk_out("reset", 0, 0, 16'h0000);
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      chk_out("scan", (i / 4) % 4, 0, 16'h0000);
    end

    // Frame-aligned update, load while digit 1
    cyc(4);
    value_in = 16'h1234; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk_out("pend", 1, 0, 16'h0000);
    cyc(10);
    chk_out("pre_wrap", 3, 0, 16'h0000);
    cyc(1);
    chk_out("upd_1234", 0, 1, 16'h1234);
    cyc(1);
    chk_out("upd_end", 0, 0, 16'h1234);
    cyc(3);
    chk_out("d1_1234", 1, 0, 16'h1234);
    cyc(4);
    chk_out("d2_1234", 2, 0, 16'h1234);
    cyc(4);
    chk_out("d3_1234", 3, 0, 16'h1234);
    cyc(4);
    chk_out("no_pend_wrap", 0, 0, 16'h1234);

    // Overwrite while pending (t = 48)
    value_in = 16'hAAAA; load = 1'b1;
    cyc(1);
    value_in = 16'h5555;
    cyc(1);
    load = 1'b0;
    for (int t = 51; t <= 63; t++) begin
      cyc(1);
      chk_out("ovr_wait", (t % 16) / 4, 0, 16'h1234);
    end
    cyc(1);
    chk_out("upd_5555", 0, 1, 16'h5555);

    // Simultaneous load and boundary: 0x1111 pending, 0xBEEF on the tick
    value_in = 16'h1111; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk_out("pend_1111", 0, 0, 16'h5555);
    for (int t = 66; t <= 79; t++) begin
      cyc(1);
      chk_out("sim_wait", (t % 16) / 4, 0, 16'h5555);
    end
    value_in = 16'hBEEF; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk_out("upd_beef", 0, 1, 16'hBEEF);
    for (int t = 81; t <= 96; t++) begin
      cyc(1);
      chk_out("beef_frame", (t % 16) / 4, 0, 16'hBEEF);
    end

    // Reset mid-handshake
    value_in = 16'h9999; load = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int t = 98; t <= 110; t++) begin
      cyc(1);
      chk_out("pend_9999", (t % 16) / 4, 0, 16'hBEEF);
    end
    reset_n = 1'b0;
    cyc(1);
    chk_out("mid_reset", 0, 0, 16'h0000);
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      chk_out("post_reset", (i / 4) % 4, 0, 16'h0000);
    end

    // Small value, exercises leading-zero blanking when enabled
    value_in = 16'h0042; load = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int i = 22; i <= 31; i++) begin
      cyc(1);
      chk_out("wait_0042", (i / 4) % 4, 0, 16'h0000);
    end
    for (int i = 32; i <= 47; i++) begin
      cyc(1);
      chk_out("show_0042", (i / 4) % 4, (i == 32) ? 1 : 0, 16'h0042);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
